// File: rtl/serial_host_initiator.sv
// serial_host_initiator: one parallel register request -> serial command bytes -> response.
// Optional response timeout built when SERIAL_HOST_TIMEOUT_EN is defined.
module serial_host_initiator #(
  parameter int unsigned PERIPH_ADDR_WIDTH = 4,
  parameter int unsigned REG_ADDR_WIDTH    = 8,
  parameter logic [7:0]  ACK_BYTE          = 8'hAC,
  parameter int unsigned TIMEOUT_CYCLES    = 100_000
) (
  input  logic                         clk_100mhz,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [1:0]                   cmd_len,
  input  logic [PERIPH_ADDR_WIDTH-1:0] cmd_periph,
  input  logic [REG_ADDR_WIDTH-1:0]    cmd_reg,
  input  logic [31:0]                  cmd_wdata,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rsp_valid,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HDR,
    S_SEND_REG,
    S_SEND_DATA,
    S_WAIT_RSP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  len_q, len_d;
  logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  cnt_nx;
  logic        cmd_ready_q, cmd_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef SERIAL_HOST_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  assign cnt_nx = cnt_q + 2'd1;

  assign cmd_ready = cmd_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and next-output logic for the request/serialise/collect sequence
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    len_d       = len_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef SERIAL_HOST_TIMEOUT_EN
    to_d        = to_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          wr_d        = cmd_write;
          len_d       = cmd_len;
          reg_d       = cmd_reg;
          wdata_d     = cmd_wdata;
          cnt_d       = 2'd0;
          cmd_ready_d = 1'b0;
          tx_valid_d  = 1'b1;
          tx_data_d   = {cmd_write, 1'b0, cmd_len, cmd_periph};
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = S_SEND_HDR;
        end
      end
      S_SEND_HDR: begin
        if (tx_ready) begin
          tx_data_d = 8'(reg_q);
          state_d   = S_SEND_REG;
        end
      end
      S_SEND_REG: begin
        if (tx_ready) begin
          cnt_d = 2'd0;
          if (wr_q) begin
            tx_data_d = wdata_q[7:0];
            state_d   = S_SEND_DATA;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_WAIT_RSP;
`ifdef SERIAL_HOST_TIMEOUT_EN
            to_d       = '0;
`endif
          end
        end
      end
      S_SEND_DATA: begin
        if (tx_ready) begin
          if (cnt_q == len_q) begin
            tx_valid_d = 1'b0;
            cnt_d      = 2'd0;
            state_d    = S_WAIT_RSP;
`ifdef SERIAL_HOST_TIMEOUT_EN
            to_d       = '0;
`endif
          end else begin
            cnt_d     = cnt_nx;
            tx_data_d = wdata_q[{cnt_nx, 3'b000} +: 8];
          end
        end
      end
      S_WAIT_RSP: begin
        if (rx_valid) begin
`ifdef SERIAL_HOST_TIMEOUT_EN
          to_d = '0;
`endif
          if (wr_q) begin
            rsp_err_d   = (rx_data != ACK_BYTE);
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            rsp_rdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
            if (cnt_q == len_q) begin
              rsp_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              cnt_d = cnt_nx;
            end
          end
        end
`ifdef SERIAL_HOST_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        cmd_ready_d = 1'b1;
        tx_valid_d  = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer in flight
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      len_q       <= 2'd0;
      reg_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= 2'd0;
      cmd_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef SERIAL_HOST_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      len_q       <= len_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef SERIAL_HOST_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

endmodule
